// File: rtl/sd_bd_fetch_if.sv
// BD store bus between sd_bd_fetch (master) and the descriptor store (slave):
// free-slot count, single-word read handshake and descriptor-complete strobe.
interface sd_bd_fetch_if #(
  parameter int unsigned BD_WIDTH = 5
);
  logic [BD_WIDTH-1:0] free_bd;
  logic                re_s;
  logic                ack_i_s;
  logic [31:0]         dat_in_s;
  logic                a_cmp;

  modport master (
    input  free_bd,
    input  ack_i_s,
    input  dat_in_s,
    output re_s,
    output a_cmp
  );

  modport slave (
    output free_bd,
    output ack_i_s,
    output dat_in_s,
    input  re_s,
    input  a_cmp
  );
endinterface

// File: rtl/sd_bd_fetch.sv
// Fetches two-word buffer descriptors (buffer address, block address) from the BD store and
// runs one data-engine transfer per descriptor. Optional watchdog: SD_BD_FETCH_TIMEOUT_EN.
module sd_bd_fetch #(
  parameter int unsigned BD_WIDTH    = 5,
  parameter int unsigned BD_CAPACITY = 8,
  parameter int unsigned TMO_CYCLES  = 65535
) (
  input  logic          clk,
  input  logic          rst,
  sd_bd_fetch_if.master bd,
  output logic          start_o,
  output logic [31:0]   buf_addr_o,
  output logic [31:0]   blk_addr_o,
  input  logic          done_i,
  input  logic          err_i,
  output logic          busy_o,
  output logic          err_o,
  output logic          tmo_o,
  input  logic          clr_err_i
);

  if (BD_CAPACITY == 0 || BD_CAPACITY > (2 ** BD_WIDTH) - 1) begin : g_bad_capacity
    $error("BD_CAPACITY must be nonzero and representable in BD_WIDTH bits");
  end
  if (TMO_CYCLES == 0) begin : g_bad_tmo
    $error("TMO_CYCLES must be nonzero");
  end

  typedef enum logic [3:0] {
    StIdle,
    StRdSrc,
    StWaitSrc,
    StRdBlk,
    StWaitBlk,
    StStart,
    StXfer,
    StCmp,
    StGap
  } state_e;

  state_e      state_q;
  logic        armed_q;
  logic        phase_q;
  logic        re_q;
  logic        cmp_q;
  logic        start_q;
  logic        busy_q;
  logic        err_q;
  logic [31:0] buf_q;
  logic [31:0] blk_q;
  logic        fetch_req;

`ifdef SD_BD_FETCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TMO_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TMO_CYCLES - 1);
  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_q;
`endif

  // Pending = BD_CAPACITY - free_bd; a reading above capacity is treated as empty.
  assign fetch_req = bd.free_bd < BD_WIDTH'(BD_CAPACITY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      phase_q   <= 1'b0;
      re_q      <= 1'b0;
      cmp_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      buf_q     <= 32'h0;
      blk_q     <= 32'h0;
`ifdef SD_BD_FETCH_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      // armed_q delays the first fetch to the second edge after reset release.
      armed_q <= 1'b1;
      re_q    <= 1'b0;
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (armed_q && fetch_req) begin
            state_q <= StRdSrc;
            re_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StRdSrc: state_q <= StWaitSrc;
        StWaitSrc: begin
          if (bd.ack_i_s) begin
            buf_q   <= bd.dat_in_s;
            state_q <= StRdBlk;
            re_q    <= 1'b1;
          end
        end
        StRdBlk: state_q <= StWaitBlk;
        StWaitBlk: begin
          if (bd.ack_i_s) begin
            blk_q   <= bd.dat_in_s;
            state_q <= StStart;
            start_q <= 1'b1;
          end
        end
        StStart: begin
          state_q <= StXfer;
`ifdef SD_BD_FETCH_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StXfer: begin
          if (done_i || err_i) begin
            state_q <= StCmp;
            cmp_q   <= 1'b1;
            phase_q <= 1'b0;
            if (err_i) begin
              err_q <= 1'b1;
            end
          end
`ifdef SD_BD_FETCH_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            state_q <= StCmp;
            cmp_q   <= 1'b1;
            phase_q <= 1'b0;
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        // Two-cycle complete strobe then two quiet cycles, so the store frees exactly one
        // slot even when a descriptor write lands in the same window.
        StCmp: begin
          if (phase_q) begin
            cmp_q   <= 1'b0;
            phase_q <= 1'b0;
            state_q <= StGap;
          end else begin
            phase_q <= 1'b1;
          end
        end
        StGap: begin
          if (phase_q) begin
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            phase_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          phase_q <= 1'b0;
          cmp_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
      // Clear wins over a same-cycle set.
      if (clr_err_i) begin
        err_q <= 1'b0;
`ifdef SD_BD_FETCH_TIMEOUT_EN
        tmo_q <= 1'b0;
`endif
      end
    end
  end

  assign bd.re_s    = re_q;
  assign bd.a_cmp   = cmp_q;
  assign start_o    = start_q;
  assign buf_addr_o = buf_q;
  assign blk_addr_o = blk_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
`ifdef SD_BD_FETCH_TIMEOUT_EN
  assign tmo_o      = tmo_q;
`else
  assign tmo_o      = 1'b0;
`endif

endmodule

// File: tb/tb_sd_bd_fetch.sv
// Randomized bench for sd_bd_fetch: a queue-based BD store and a delay-based data engine
// drive the DUT; descriptor contents, strobe shapes and error flags are checked per cycle.
module tb_sd_bd_fetch;
  localparam int BdWidth   = 5;
  localparam int BdCap     = 8;
  localparam int TmoCycles = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_o;
  logic [31:0] buf_addr_o;
  logic [31:0] blk_addr_o;
  logic        done_i;
  logic        err_i;
  logic        busy_o;
  logic        err_o;
  logic        tmo_o;
  logic        clr_err_i;

  sd_bd_fetch_if #(.BD_WIDTH(BdWidth)) bus ();

  sd_bd_fetch #(
    .BD_WIDTH   (BdWidth),
    .BD_CAPACITY(BdCap),
    .TMO_CYCLES (TmoCycles)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bd        (bus),
    .start_o   (start_o),
    .buf_addr_o(buf_addr_o),
    .blk_addr_o(blk_addr_o),
    .done_i    (done_i),
    .err_i     (err_i),
    .busy_o    (busy_o),
    .err_o     (err_o),
    .tmo_o     (tmo_o),
    .clr_err_i (clr_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] buf_a;
    logic [31:0] blk_a;
  } desc_t;

  desc_t q[$];
  int n_checks = 0, n_pass = 0, cyc = 0;
  int word_idx = 0, ack_cnt = 0, eng_cnt = 0, xfer_start = 0;
  int acmp_len = 0, post = 0, n_re = 0, n_start = 0, n_cmp = 0;
  bit ack_pend = 0, in_xfer = 0, cmp_exp = 0, exp_err = 0, exp_tmo = 0;
  bit prev_re = 0, prev_acmp = 0, prev_start = 0;
  // Stimulus knobs; -1 selects random.
  int ack_dly = -1, eng_dly = -1, kind_fix = -1;
  bit stall = 0, hold_blk = 0, push_en = 0, clr_en = 0, stray_en = 0;
  bit force_clr = 0, clr_with_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic set_free();
    bus.free_bd = BdWidth'(BdCap - q.size());
  endtask

  task automatic push_desc(input logic [31:0] b, input logic [31:0] k);
    desc_t d;
    d.buf_a = b;
    d.blk_a = k;
    q.push_back(d);
    set_free();
  endtask

  task automatic model_reset();
    q.delete();
    word_idx = 0; ack_pend = 0; in_xfer = 0; cmp_exp = 0; exp_err = 0; exp_tmo = 0;
    prev_re = 0; prev_acmp = 0; prev_start = 0; acmp_len = 0; post = 0; hold_blk = 0;
    bus.ack_i_s = 0; bus.dat_in_s = 32'h0; done_i = 0; err_i = 0; clr_err_i = 0;
    set_free();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_re_s"}, 32'(bus.re_s), 0);
    check({tag, "_a_cmp"}, 32'(bus.a_cmp), 0);
    check({tag, "_start"}, 32'(start_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_err"}, 32'(err_o), 0);
    check({tag, "_tmo"}, 32'(tmo_o), 0);
    check({tag, "_buf"}, buf_addr_o, 0);
    check({tag, "_blk"}, blk_addr_o, 0);
  endtask

  // One clock: observe DUT outputs after the edge, update the store/engine model, drive inputs.
  task automatic step();
    bit new_re, new_start, set_err, set_tmo, clr;
    int k;
    new_re = 0; new_start = 0; set_err = 0; set_tmo = 0;
    @(posedge clk);
    #1;
    cyc++;
    check("err_o", 32'(err_o), 32'(exp_err));
    check("tmo_o", 32'(tmo_o), 32'(exp_tmo));
    if (bus.re_s) begin
      n_re++;
      new_re = 1;
      check("re_s_spacing", 32'(prev_re), 0);
      check("re_s_outstanding", 32'(ack_pend), 0);
      check("re_s_has_desc", 32'(q.size() > 0), 1);
      check("re_s_busy", 32'(busy_o), 1);
      ack_pend = 1;
      if (hold_blk && word_idx == 1) ack_cnt = 1000000;
      else ack_cnt = (ack_dly >= 0) ? ack_dly : int'($urandom_range(0, 5));
    end
    if (start_o) begin
      n_start++;
      new_start = 1;
      check("start_single", 32'(prev_start), 0);
      check("start_words_read", word_idx, 2);
      if (q.size() > 0) begin
        check("start_buf_addr", buf_addr_o, q[0].buf_a);
        check("start_blk_addr", blk_addr_o, q[0].blk_a);
      end else begin
        check("start_has_desc", q.size(), 1);
      end
      in_xfer = 1;
      xfer_start = cyc;
      eng_cnt = stall ? -1 : ((eng_dly >= 0) ? eng_dly : int'($urandom_range(0, 7)));
    end
    if (in_xfer) check("xfer_busy", 32'(busy_o), 1);
    if (bus.a_cmp) begin
      if (!prev_acmp) begin
        n_cmp++;
        check("a_cmp_after_xfer", 32'(cmp_exp), 1);
        cmp_exp = 0;
        if (q.size() > 0) begin
          check("cmp_buf_addr", buf_addr_o, q[0].buf_a);
          check("cmp_blk_addr", blk_addr_o, q[0].blk_a);
          void'(q.pop_front());
        end
        word_idx = 0;
        acmp_len = 0;
      end
      acmp_len++;
      check("a_cmp_busy", 32'(busy_o), 1);
      post = 0;
    end else if (prev_acmp) begin
      check("a_cmp_len", acmp_len, 2);
      check("gap_busy", 32'(busy_o), 1);
      post = 1;
    end else if (post > 0) begin
      post++;
      check("gap_busy", 32'(busy_o), 32'(post < 3));
      if (post == 3) post = 0;
    end

    prev_re = bus.re_s;
    prev_acmp = bus.a_cmp;
    prev_start = start_o;
    bus.ack_i_s = 0;
    bus.dat_in_s = $urandom;
    done_i = 0;
    err_i = 0;
    if (ack_pend && !new_re) begin
      if (ack_cnt == 0) begin
        bus.ack_i_s = 1;
        if (q.size() > 0) bus.dat_in_s = (word_idx == 0) ? q[0].buf_a : q[0].blk_a;
        word_idx++;
        ack_pend = 0;
      end else begin
        ack_cnt--;
      end
    end else if (!ack_pend && in_xfer && stray_en && $urandom_range(0, 3) == 0) begin
      bus.ack_i_s = 1;  // stray acknowledge with junk data
    end
    if (in_xfer && !new_start) begin
      if (eng_cnt == 0) begin
        k = (kind_fix >= 0) ? kind_fix : int'($urandom_range(0, 2));
        done_i = (k != 1);
        err_i = (k != 0);
        set_err = err_i;
        in_xfer = 0;
        cmp_exp = 1;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
      end
`ifdef SD_BD_FETCH_TIMEOUT_EN
      else if (cyc - xfer_start == TmoCycles) begin
        set_err = 1;
        set_tmo = 1;
        in_xfer = 0;
        cmp_exp = 1;
      end
`endif
    end else if (!in_xfer && stray_en && $urandom_range(0, 7) == 0) begin
      err_i = 1;
      done_i = 1'($urandom_range(0, 1));
    end
    clr = force_clr || (clr_with_err && set_err) || (clr_en && $urandom_range(0, 9) == 0);
    clr_err_i = clr;
    if (clr) begin
      exp_err = 0;
      exp_tmo = 0;
    end else begin
      if (set_err) exp_err = 1;
      if (set_tmo) exp_tmo = 1;
    end
    if (push_en && q.size() < BdCap && $urandom_range(0, 5) == 0) begin
      push_desc($urandom, $urandom);
    end
    set_free();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((q.size() != 0 || in_xfer || ack_pend || post != 0 || busy_o) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_queue_empty", q.size(), 0);
    check("drain_idle", 32'(busy_o), 0);
  endtask

  task automatic clear_flags();
    force_clr = 1;
    step();
    force_clr = 0;
    step();
  endtask

  initial begin
    int r0, s0, c0;
    rst = 1;
    model_reset();
    #12;
    check_all_zero("reset");

    // Single descriptor, ack one cycle after each read, plain done.
    push_desc(32'h0000_1000, 32'h0000_0020);
    ack_dly = 0; eng_dly = 0; kind_fix = 0;
    r0 = n_re; s0 = n_start; c0 = n_cmp;
    @(negedge clk);
    rst = 0;
    step();
    check("first_edge_no_re_s", 32'(bus.re_s), 0);
    drain(200);
    check("t1_buf_addr", buf_addr_o, 32'h0000_1000);
    check("t1_blk_addr", blk_addr_o, 32'h0000_0020);
    check("t1_re_count", n_re - r0, 2);
    check("t1_start_count", n_start - s0, 1);
    check("t1_cmp_count", n_cmp - c0, 1);

    // Two queued descriptors.
    r0 = n_re; s0 = n_start; c0 = n_cmp;
    push_desc(32'hA000_0000, 32'h0000_0100);
    push_desc(32'hB000_0040, 32'h0000_0200);
    drain(300);
    check("t2_re_count", n_re - r0, 4);
    check("t2_start_count", n_start - s0, 2);
    check("t2_cmp_count", n_cmp - c0, 2);

    // Error and done together: sticky error, descriptor still completed, then cleared.
    c0 = n_cmp;
    kind_fix = 2;
    push_desc(32'h1234_5678, 32'h0000_0007);
    drain(200);
    check("t3_err_set", 32'(err_o), 1);
    check("t3_cmp_count", n_cmp - c0, 1);
    clear_flags();
    check("t3_err_cleared", 32'(err_o), 0);

    // Clear in the same cycle as an error: clear wins.
    kind_fix = 1; clr_with_err = 1;
    push_desc(32'h0BAD_0000, 32'h0000_0009);
    drain(200);
    check("t4_clr_precedence", 32'(err_o), 0);
    clr_with_err = 0;

    // Slow acknowledge.
    r0 = n_re;
    ack_dly = 5; kind_fix = 0;
    push_desc(32'hCAFE_F00D, 32'h0000_0033);
    drain(300);
    check("t5_re_count", n_re - r0, 2);
    check("t5_buf_addr", buf_addr_o, 32'hCAFE_F00D);

    // Randomized traffic with stray handshakes and random error clears.
    r0 = n_re; s0 = n_start; c0 = n_cmp;
    ack_dly = -1; eng_dly = -1; kind_fix = -1;
    push_en = 1; clr_en = 1; stray_en = 1;
    repeat (1500) step();
    push_en = 0;
    drain(2000);
    clr_en = 0; stray_en = 0;
    check("rand_start_vs_cmp", n_start - s0, n_cmp - c0);
    check("rand_re_vs_cmp", n_re - r0, 2 * (n_cmp - c0));
    clear_flags();

    // Engine never finishes.
    c0 = n_cmp;
    stall = 1; ack_dly = 0;
    push_desc(32'h5555_0000, 32'h0000_0044);
`ifdef SD_BD_FETCH_TIMEOUT_EN
    drain(300);
    check("tmo_set", 32'(tmo_o), 1);
    check("tmo_err_set", 32'(err_o), 1);
    check("tmo_cmp_count", n_cmp - c0, 1);
    stall = 0;
    clear_flags();
    check("tmo_cleared", 32'(tmo_o), 0);
`else
    repeat (110) step();
    check("stall_busy", 32'(busy_o), 1);
    check("stall_no_cmp", n_cmp - c0, 0);
    check("stall_no_tmo", 32'(tmo_o), 0);
    stall = 0;
    eng_cnt = 0;
    kind_fix = 0;
    drain(200);
    check("stall_cmp_after_done", n_cmp - c0, 1);
`endif

    // Reset while waiting for the block-address word.
    hold_blk = 1;
    push_desc(32'h7777_1111, 32'h0000_0055);
    for (int i = 0; i < 50 && !(ack_pend && word_idx == 1); i++) step();
    check("reached_wait_blk", word_idx, 1);
    step();
    #2;
    rst = 1;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    rst = 0;
    r0 = n_re;
    repeat (20) step();
    check("empty_no_re_s", n_re - r0, 0);
    check("empty_idle", 32'(busy_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
